// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the rr_arbiter8 round-robin arbiter.
package arb_pkg;

    localparam int ARB_N   = 8;
    localparam int ARB_IDW = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    function automatic logic [ARB_N-1:0] id_to_onehot(input logic [ARB_IDW-1:0] id);
        return ARB_N'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [ARB_N-1:0]   req;
    logic [ARB_N-1:0]   gnt;
    logic [ARB_IDW-1:0] gnt_id;
    logic               gnt_valid;
    logic               timeout_evt;

    modport master (
        output req,
        input  gnt, gnt_id, gnt_valid, timeout_evt
    );

    modport slave (
        input  req,
        output gnt, gnt_id, gnt_valid, timeout_evt
    );

endinterface

// File: rtl/rr_arbiter8_prio_enc.sv
// 8-to-3 priority encoder: the highest set input bit wins; valid when any bit is set.
module prio_enc_8to3
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]   in_i,
    output logic [ARB_IDW-1:0] out_o,
    output logic               valid_o
);

    // NOTE: out_o is defaulted before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        out_o   = '0;
        valid_o = |in_i;
        for (int i = 0; i < ARB_N; i++) begin
            if (in_i[i]) out_o = ARB_IDW'(i);
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with grant hold until release.
// Optional forced hand-over after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W) - 1) begin : g_bad_cfg
        $error("rr_arbiter8: CNT_W too narrow for MAX_HOLD");
    end

    arb_state_e         state_q, state_d;
    logic [ARB_N-1:0]   gnt_q, gnt_d;
    logic [ARB_IDW-1:0] gnt_id_q, gnt_id_d;
    logic [ARB_IDW-1:0] last_id_q, last_id_d;
    logic               timeout_q, timeout_d;

    logic [ARB_N-1:0]   arb_req;
    logic [ARB_N-1:0]   low_req;
    logic [ARB_IDW-1:0] low_id, full_id, win_id;
    logic               low_vld, full_vld, win_vld;
    logic               load;

    // The current owner is masked out so it can never win on its own release or timeout edge.
    always_comb begin
        arb_req = bus.req;
        if (state_q == ARB_GRANT) arb_req = bus.req & ~gnt_q;
        low_req = arb_req & ((ARB_N'(1) << last_id_q) - ARB_N'(1));
    end

    prio_enc_8to3 u_enc_low (
        .in_i    (low_req),
        .out_o   (low_id),
        .valid_o (low_vld)
    );

    prio_enc_8to3 u_enc_full (
        .in_i    (arb_req),
        .out_o   (full_id),
        .valid_o (full_vld)
    );

    assign win_id  = low_vld ? low_id : full_id;
    assign win_vld = full_vld;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        timeout_d = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (win_vld) load = 1'b1;
            end
            ARB_GRANT: begin
                if (!bus.req[gnt_id_q]) begin
                    if (win_vld) begin
                        load = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1) && win_vld) begin
                    load      = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase

        if (load) begin
            state_d   = ARB_GRANT;
            gnt_d     = id_to_onehot(win_id);
            gnt_id_d  = win_id;
            last_id_d = win_id;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Saturates at MAX_HOLD-1 so a late-arriving requester still triggers the hand-over.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (load) begin
            hold_cnt_d = '0;
        end else if (state_q == ARB_GRANT && hold_cnt_q != CNT_W'(MAX_HOLD - 1)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) hold_cnt_q <= '0;
        else        hold_cnt_q <= hold_cnt_d;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_id_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.gnt_valid   = |gnt_q;
    assign bus.timeout_evt = timeout_q;

endmodule
